// File: rtl/fastram_pkg.sv
// Shared constants for the TF530 synchronous fast-RAM controller:
// FSM state codes, 68030 SIZ encodings and byte-lane indices.
package fastram_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_3B   = 2'b11;

  // Lane 3 carries D31:24, i.e. the byte at A[1:0]=00.
  localparam int LANE_D31 = 3;
  localparam int LANE_D23 = 2;
  localparam int LANE_D15 = 1;
  localparam int LANE_D7  = 0;

  function automatic int siz_bytes(input logic [1:0] siz);
    return (siz == SIZ_LONG) ? 4 : int'(siz);
  endfunction

endpackage

// File: rtl/fastram_lane_decode.sv
// Active-low SRAM byte-lane mask for a 68030 write, from SIZ and A[1:0]
// under dynamic bus sizing (bytes past the end of the longword are dropped).
module fastram_lane_decode
  import fastram_pkg::*;
(
  input  logic [1:0] siz,
  input  logic [1:0] a_lo,
  output logic [3:0] lane_n
);

  always_comb begin
    lane_n = 4'hF;
    for (int i = 0; i < 4; i++) begin
      // lane i serves byte offset 3-i within the longword
      if (((3 - i) >= int'(a_lo)) && ((3 - i) < (int'(a_lo) + siz_bytes(siz)))) begin
        lane_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fastram_burst.sv
// Synchronous 68030 fast-RAM controller: programmable wait states, STERM
// termination and CBREQ/CBACK cache-line burst fills for the TF530 SRAM bank.
module fastram_burst
  import fastram_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int BURST_EN    = 1,
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 4
) (
  input  logic              CLKCPU,
  input  logic              RESET,
  input  logic              ACCESS,
  input  logic [ADDR_W-1:0] A,
  input  logic [1:0]        SIZ,
  input  logic              AS20,
  input  logic              RW20,
  input  logic              DS20,
  input  logic              CBREQ,
  output logic              CBACK,
  output logic              STERM,
  output logic              CIIN,
  output logic [1:0]        RA,
  output logic [3:0]        RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] WS_LOAD     = 3'(WAIT_STATES);
  localparam logic [1:0] LAST_BEAT   = 2'(BURST_LEN - 1);
  localparam logic [1:0] FIRST_STATE = (WAIT_STATES == 0) ? S_TERM : S_WAIT;

  logic [1:0] state_q, state_d;
  logic       rw_q, rw_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] alo_q, alo_d;
  logic [1:0] ra_q, ra_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [1:0] beat_q, beat_d;
  logic       burst_q, burst_d;
  logic       go_idle;
  logic       active;
  logic [3:0] lane_n;
  logic       unused_a;

  assign unused_a = ^A[ADDR_W-1:4];

  // Bus handshake: a cycle is requested by ACCESS=0 & AS20=0 sampled at a
  // rising edge; each longword is accepted by the CPU on the edge that ends
  // the single clock in which STERM=0. AS20=1 at any edge ends the cycle.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    siz_d   = siz_q;
    alo_d   = alo_q;
    ra_d    = ra_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    go_idle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ACCESS && !AS20) begin
          state_d = FIRST_STATE;
          rw_d    = RW20;
          siz_d   = SIZ;
          alo_d   = A[1:0];
          ra_d    = A[3:2];
          wcnt_d  = WS_LOAD;
          beat_d  = 2'd0;
          burst_d = (BURST_EN != 0) && RW20 && !CBREQ;
        end
      end
      S_WAIT: begin
        if (AS20) begin
          go_idle = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
          if (wcnt_q <= 3'd1) state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (AS20) begin
          go_idle = 1'b1;
        end else if (!burst_q || (beat_q == LAST_BEAT)) begin
          state_d = S_DONE;
        end else begin
          // RA wraps 3->0, matching the 68030 line-fill order
          beat_d  = beat_q + 2'd1;
          ra_d    = ra_q + 2'd1;
          wcnt_d  = WS_LOAD;
          state_d = FIRST_STATE;
        end
      end
      default: begin
        if (AS20) go_idle = 1'b1;
      end
    endcase
    if (go_idle) begin
      state_d = S_IDLE;
      ra_d    = 2'd0;
      wcnt_d  = 3'd0;
      beat_d  = 2'd0;
      burst_d = 1'b0;
    end
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      siz_q   <= 2'd0;
      alo_q   <= 2'd0;
      ra_q    <= 2'd0;
      wcnt_q  <= 3'd0;
      beat_q  <= 2'd0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      siz_q   <= siz_d;
      alo_q   <= alo_d;
      ra_q    <= ra_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
    end
  end

  fastram_lane_decode u_lane (
    .siz    (siz_q),
    .a_lo   (alo_q),
    .lane_n (lane_n)
  );

  assign active    = (state_q == S_WAIT) || (state_q == S_TERM);
  assign CBACK     = ~(active & burst_q);
  assign STERM     = ~(state_q == S_TERM);
  assign CIIN      = AS20 | ~ACCESS;
  assign RA        = ra_q;
  assign RAMCS     = !active ? 4'hF : (rw_q ? 4'h0 : lane_n);
  assign RAMOE     = ~(active & rw_q);
  assign RAMWE     = ~(active & ~rw_q & ~DS20);
  assign dbg_state = state_q;

endmodule

// File: doc/fastram_burst.md
Name: fastram_burst

Overview:
- Synchronous 68030 fast-RAM controller for the TF530 SRAM bank: the parametrised successor to the combinational fast-RAM decode.
- Adds programmable wait states, synchronous termination (STERM), and 68030 cache-line burst fills (CBREQ/CBACK) with an internal longword counter.
- Sits between the 68030 bus signals and the four byte-lane SRAM chip selects, clocked by the CPU clock.

Parameters:
- WAIT_STATES, 1, clocks inserted before each STERM beat (0..7).
- BURST_EN, 1, 1 = honour CBREQ on reads; 0 = CBACK held negated.
- ADDR_W, 24, width of A.
- BURST_LEN, 4, longwords per burst (power of two, 2..4).

Ports:
- CLKCPU, in, 1, CPU clock; all state updates on the rising edge.
- RESET, in, 1, synchronous, active-high.
- ACCESS, in, 1, active-low fast-RAM address match.
- A, in, ADDR_W, CPU address.
- SIZ, in, 2, 68030 transfer size.
- AS20, in, 1, active-low address strobe.
- RW20, in, 1, 1 = read.
- DS20, in, 1, active-low data strobe.
- CBREQ, in, 1, active-low burst request.
- CBACK, out, 1, active-low burst acknowledge.
- STERM, out, 1, active-low synchronous termination.
- CIIN, out, 1, active-low cache inhibit; high (cacheable) for fast RAM.
- RA, out, 2, longword address within the line (replaces A[3:2] at the RAM).
- RAMCS, out, 4, active-low byte-lane chip selects.
- RAMOE, out, 1, active-low output enable.
- RAMWE, out, 1, active-low write enable.

Behaviour:
- Reset values: CBACK=1, STERM=1, CIIN=1, RAMCS=4'hF, RAMOE=1, RAMWE=1, RA=0, state=IDLE, counters=0.
- States: IDLE, WAIT, TERM, DONE.
- IDLE -> start when ACCESS=0 and AS20=0 are sampled together.
  - On start, latch RW20, SIZ and A[1:0]; load RA=A[3:2]; load wcnt=WAIT_STATES; load beat=0.
  - burst = BURST_EN & RW20 & ~CBREQ; CBACK=~burst from the start edge.
  - Next state is TERM if WAIT_STATES=0, otherwise WAIT.
- WAIT: decrement wcnt each clock; go to TERM on the clock after wcnt reaches 1.
- TERM: STERM=0 for exactly one clock.
  - Single transfer, or last beat (beat = BURST_LEN-1): go to DONE.
  - Otherwise: beat+1, RA+1 modulo 4 (wrap 3->0; the 68030 wrapping order), reload wcnt, go to WAIT (or TERM again if WAIT_STATES=0).
- DONE: all strobes negated; return to IDLE when AS20=1 is sampled. This prevents a retrigger within one bus cycle.
- RAMOE=0 while a read is active (WAIT/TERM).
- RAMWE=0 in WAIT/TERM of a write, gated by DS20=0.
- RAMCS during a read: all four lanes 0.
- RAMCS during a write: lane decode from latched SIZ and A[1:0]. Lane 3 = D31:24 (the A[1:0]=00 byte), per 68030 dynamic sizing:
  - byte: one lane;
  - word: two lanes, or one lane at A=11;
  - 3-byte: three lanes from offset;
  - long (SIZ=00): from offset to lane 0.
- CIIN=0 only when ACCESS=1; no other output is driven for non-fast-RAM cycles.
- Writes never burst: CBACK stays 1 even with CBREQ=0.
- CBREQ negated mid-burst: ignored; the burst runs to completion.
- AS20 negated in WAIT/TERM (abort): next clock goes to IDLE with all outputs at reset values; no further STERM.
- RESET asserted mid-burst: reset values on the next edge, regardless of state.
- Back-to-back cycles: a new start is accepted no earlier than one clock after the DONE->IDLE transition.

Decomposition:
- Package fastram_pkg: state enum (IDLE/WAIT/TERM/DONE), SIZ encodings (SIZ_LONG=00, SIZ_BYTE=01, SIZ_WORD=10, SIZ_3B=11), lane index constants.
- Sub-module fastram_lane_decode: purely combinational SIZ/A[1:0] -> 4-bit active-low lane mask. It is unit-tested exhaustively (16 cases).

Test Plan:
- Reset then idle, AS20=1 -> all outputs at reset values; STERM never low over 20 clocks.
- WAIT_STATES=1, long read at A=0x200004, CBREQ=1 -> STERM low on the 3rd clock after start, for 1 clock; RAMCS=0000, RAMOE=0; CBACK stays 1.
- Burst read at A[3:2]=10, CBREQ=0, WAIT_STATES=0 -> CBACK=0; four STERM pulses on consecutive clocks; RA=2,3,0,1; DONE until AS20=1.
- Byte write SIZ=01 at A[1:0]=10, DS20=0 -> RAMCS=1101, RAMWE=0, RAMOE=1; CBACK=1 even with CBREQ=0.
- AS20 negated during the WAIT of beat 2 in a burst -> IDLE next clock, no further STERM, RAMCS=1111.
- RESET pulsed during TERM -> next clock all outputs at reset values; a fresh start after release completes normally.
